// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: field layout, opcode encodings and FSM states.
package fetch_sequencer_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 28;
    localparam int OPD_W   = 24;
    localparam int OPC_MSB = 27;
    localparam int OPC_LSB = 24;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_JMP = 4'h1;
    localparam logic [3:0] OPC_STO = 4'h2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: ROM address/data, issue handshake and branch redirect.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic               run;
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instruction;
    logic               valid;
    logic               ready;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_addr;
    logic               busy;

    modport master (
        input  run, rom_data, ready, branch_taken, branch_addr,
        output address, instruction, valid, busy
    );

    modport slave (
        output run, rom_data, ready, branch_taken, branch_addr,
        input  address, instruction, valid, busy
    );

endinterface

// File: rtl/fetch_sequencer_delay_counter.sv
// 24-bit loadable down counter used to stall the sequencer on NOP delays.
module delay_counter
    import fetch_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [OPD_W-1:0] load_value,
    input  logic             dec,
    output logic [OPD_W-1:0] count,
    output logic             zero
);

    // Counter register; clear has priority over load, and it never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 24'd0;
        end else if (clear) begin
            count <= 24'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 24'd0)) begin
            count <= count - 24'd1;
        end else begin
            count <= count;
        end
    end

    assign zero = (count == 24'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer driving a combinational instruction ROM.
// Optional feature macro NOP_DELAY_EN: NOP operand becomes a stall count (DELAY state).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  pc_r, pc_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic               valid_r, valid_s;
    logic [3:0]         opcode_s;

    assign opcode_s = instr_r[OPC_MSB:OPC_LSB];

`ifdef NOP_DELAY_EN
    logic             busy_r, busy_s;
    logic             cnt_load_s, cnt_dec_s, cnt_clear_s, cnt_zero_s;
    logic [OPD_W-1:0] cnt_value_s;

    delay_counter u_delay_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear_s),
        .load       (cnt_load_s),
        .load_value (instr_r[OPD_W-1:0]),
        .dec        (cnt_dec_s),
        .count      (cnt_value_s),
        .zero       (cnt_zero_s)
    );
`endif

    // Next-state and next-output logic; a branch redirect beats everything except reset.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        valid_s = valid_r;
`ifdef NOP_DELAY_EN
        busy_s      = busy_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_clear_s = 1'b0;
`endif
        if (bus.branch_taken) begin
            pc_s    = bus.branch_addr;
            valid_s = 1'b0;
            state_s = ST_FETCH;
`ifdef NOP_DELAY_EN
            busy_s      = 1'b0;
            cnt_clear_s = 1'b1;
`endif
        end else if (bus.run) begin
            case (state_r)
                ST_FETCH: begin
                    instr_s = bus.rom_data;
                    valid_s = 1'b1;
                    state_s = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.ready) begin
                        valid_s = 1'b0;
                        state_s = ST_FETCH;
                        if (opcode_s == OPC_JMP) begin
                            pc_s = instr_r[ADDR_W-1:0];
                        end
`ifdef NOP_DELAY_EN
                        else if ((opcode_s == OPC_NOP) && (instr_r[OPD_W-1:0] != 24'd0)) begin
                            cnt_load_s = 1'b1;
                            busy_s     = 1'b1;
                            state_s    = ST_DELAY;
                        end
`endif
                        else begin
                            pc_s = next_pc(pc_r);
                        end
                    end else begin
                        valid_s = 1'b1;
                    end
                end
                ST_DELAY: begin
`ifdef NOP_DELAY_EN
                    // Leaving on count==1 makes the stall exactly operand cycles long.
                    cnt_dec_s = 1'b1;
                    if ((cnt_value_s == 24'd1) || cnt_zero_s) begin
                        pc_s    = next_pc(pc_r);
                        busy_s  = 1'b0;
                        state_s = ST_FETCH;
                    end else begin
                        busy_s = 1'b1;
                    end
`else
                    state_s = ST_FETCH;
`endif
                end
                default: begin
                    valid_s = 1'b0;
                    state_s = ST_FETCH;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            pc_r    <= 16'h0000;
            instr_r <= 28'h0000000;
            valid_r <= 1'b0;
`ifdef NOP_DELAY_EN
            busy_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            valid_r <= valid_s;
`ifdef NOP_DELAY_EN
            busy_r  <= busy_s;
`endif
        end
    end

    assign bus.address     = pc_r;
    assign bus.instruction = instr_r;
    assign bus.valid       = valid_r;
`ifdef NOP_DELAY_EN
    assign bus.busy        = busy_r;
`else
    assign bus.busy        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

`ifdef NOP_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if ifc ();
    logic [27:0] rom [0:65535];
    assign ifc.rom_data = rom[ifc.address];

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: PC, whether an instruction is on offer, and remaining stall cycles.
    logic [15:0] m_pc      = 16'h0000;
    bit          m_offered = 1'b0;
    logic [27:0] m_instr   = 28'h0;
    int          m_stall   = 0;

    task automatic model_update();
        logic [23:0] opd;
        if (rst) begin
            m_pc = 16'h0000; m_offered = 1'b0; m_instr = 28'h0; m_stall = 0;
        end else if (ifc.branch_taken) begin
            m_pc = ifc.branch_addr; m_offered = 1'b0; m_stall = 0;
        end else if (ifc.run) begin
            if (m_stall > 0) begin
                m_stall = m_stall - 1;
                if (m_stall == 0) m_pc = m_pc + 16'd1;
            end else if (!m_offered) begin
                m_instr = rom[m_pc];
                m_offered = 1'b1;
            end else if (ifc.ready) begin
                m_offered = 1'b0;
                opd = m_instr[23:0];
                case (m_instr[27:24])
                    OPC_JMP: m_pc = opd[15:0];
                    OPC_NOP: begin
                        if (DELAY_EN && opd != 24'd0) m_stall = int'(opd);
                        else m_pc = m_pc + 16'd1;
                    end
                    default: m_pc = m_pc + 16'd1;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ifc.run = 1'b1; ifc.ready = 1'b1;
        ifc.branch_taken = 1'b1; ifc.branch_addr = 16'h1234;
        step(); step();
        checks++; if (ifc.address !== 16'h0000) begin errors++; $display("FAIL reset_address: got %h expected 0000", ifc.address); end
        checks++; if (ifc.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifc.valid); end
        checks++; if (ifc.instruction !== 28'h0) begin errors++; $display("FAIL reset_instruction: got %h expected 0000000", ifc.instruction); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
        ifc.branch_taken = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        int issues = 0;
        for (int i = 0; i < 4; i++) rom[i] = {OPC_STO, 24'h0000A0 + 24'(i)};
        ifc.run = 1'b1; ifc.ready = 1'b1;
        do_reset();
        checks++; if (ifc.valid !== 1'b0) begin errors++; $display("FAIL seq_valid_after_reset: got %b expected 0", ifc.valid); end
        for (int i = 0; i < 6; i++) begin
            if (ifc.valid && ifc.ready) issues++;
            step();
            checks++; if (ifc.address !== m_pc || ifc.valid !== m_offered) begin
                errors++; $display("FAIL seq_cycle%0d: got addr=%h valid=%b expected addr=%h valid=%b", i, ifc.address, ifc.valid, m_pc, m_offered);
            end
        end
        checks++; if (issues != 3) begin errors++; $display("FAIL seq_issue_count: got %0d expected 3", issues); end
        checks++; if (ifc.address !== 16'd3) begin errors++; $display("FAIL seq_final_address: got %h expected 0003", ifc.address); end
    endtask

    task automatic test_nop_delay();
        int busy_cycles = 0;
        bit seen = 1'b0;
        bit done = 1'b0;
        rom[0] = {OPC_NOP, 24'd4000};
        rom[1] = {OPC_STO, 24'h000001};
        ifc.run = 1'b1; ifc.ready = 1'b1;
        do_reset();
        if (DELAY_EN) begin
            for (int i = 0; i < 6000 && !done; i++) begin
                step();
                if (ifc.busy) begin busy_cycles++; seen = 1'b1; end
                else if (seen) done = 1'b1;
            end
            checks++; if (!done) begin errors++; $display("FAIL nop_delay_timeout: got busy_cycles=%0d expected delay to end", busy_cycles); end
            checks++; if (busy_cycles != 4000) begin errors++; $display("FAIL nop_delay_length: got %0d expected 4000", busy_cycles); end
        end else begin
            step(); step(); step();
            checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b expected 0", ifc.busy); end
        end
        checks++; if (ifc.address !== 16'd1 || ifc.address !== m_pc) begin
            errors++; $display("FAIL nop_after_address: got %h expected 0001 (model %h)", ifc.address, m_pc);
        end
    endtask

    task automatic test_jmp_loop();
        for (int i = 0; i < 5; i++) rom[i] = {OPC_STO, 24'(i)};
        rom[5] = {OPC_JMP, 8'd0, 16'd0};
        ifc.run = 1'b1; ifc.ready = 1'b1;
        do_reset();
        ifc.branch_taken = 1'b1; ifc.branch_addr = 16'd5;
        step();
        ifc.branch_taken = 1'b0;
        checks++; if (ifc.address !== 16'd5) begin errors++; $display("FAIL jmp_redirect: got %h expected 0005", ifc.address); end
        step();
        checks++; if (ifc.instruction !== 28'h1000000) begin errors++; $display("FAIL jmp_fetch: got %h expected 1000000", ifc.instruction); end
        step();
        checks++; if (ifc.address !== 16'd0) begin errors++; $display("FAIL jmp_target: got %h expected 0000", ifc.address); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (ifc.address !== 16'd5 || ifc.address !== m_pc) begin errors++; $display("FAIL jmp_loop_reach: got %h expected 0005", ifc.address); end
        step(); step();
        checks++; if (ifc.address !== 16'd0) begin errors++; $display("FAIL jmp_loop_repeat: got %h expected 0000", ifc.address); end
    endtask

    task automatic test_stall_ready();
        logic [27:0] exp_instr;
        exp_instr = {OPC_STO, 24'h00BEEF};
        rom[0] = exp_instr;
        ifc.run = 1'b1; ifc.ready = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (ifc.valid !== 1'b1 || ifc.instruction !== exp_instr || ifc.address !== 16'd0) begin
                errors++; $display("FAIL stall_hold%0d: got valid=%b instr=%h addr=%h expected 1 %h 0000", i, ifc.valid, ifc.instruction, ifc.address, exp_instr);
            end
        end
        ifc.ready = 1'b1;
        step();
        checks++; if (ifc.address !== 16'd1 || ifc.valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got addr=%h valid=%b expected 0001 0", ifc.address, ifc.valid);
        end
    endtask

    task automatic test_branch_in_delay();
        rom[0] = {OPC_NOP, 24'd200};
        ifc.run = 1'b1; ifc.ready = 1'b1;
        do_reset();
        step(); step();
        for (int i = 0; i < 100; i++) step();
        checks++; if (ifc.busy !== DELAY_EN) begin errors++; $display("FAIL branch_pre_busy: got %b expected %b", ifc.busy, DELAY_EN); end
        ifc.branch_taken = 1'b1; ifc.branch_addr = 16'h0040;
        step();
        ifc.branch_taken = 1'b0;
        checks++; if (ifc.address !== 16'h0040 || ifc.busy !== 1'b0 || ifc.valid !== 1'b0) begin
            errors++; $display("FAIL branch_redirect: got addr=%h busy=%b valid=%b expected 0040 0 0", ifc.address, ifc.busy, ifc.valid);
        end
        step();
        checks++; if (ifc.valid !== 1'b1 || ifc.address !== 16'h0040) begin
            errors++; $display("FAIL branch_refetch: got valid=%b addr=%h expected 1 0040", ifc.valid, ifc.address);
        end
    endtask

    task automatic test_wrap_and_reset_handshake();
        rom[16'hFFFF] = {OPC_STO, 24'h00FFFF};
        ifc.run = 1'b1; ifc.ready = 1'b1;
        do_reset();
        ifc.branch_taken = 1'b1; ifc.branch_addr = 16'hFFFF;
        step();
        ifc.branch_taken = 1'b0;
        step();
        checks++; if (ifc.valid !== 1'b1 || ifc.address !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_fetch: got valid=%b addr=%h expected 1 ffff", ifc.valid, ifc.address);
        end
        step();
        checks++; if (ifc.address !== 16'h0000) begin errors++; $display("FAIL wrap_address: got %h expected 0000", ifc.address); end
        ifc.branch_taken = 1'b1; ifc.branch_addr = 16'h0010;
        step();
        ifc.branch_taken = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (ifc.address !== 16'h0000 || ifc.valid !== 1'b0 || ifc.instruction !== 28'h0) begin
            errors++; $display("FAIL reset_on_handshake: got addr=%h valid=%b instr=%h expected 0000 0 0000000", ifc.address, ifc.valid, ifc.instruction);
        end
        step();
        checks++; if (ifc.address !== 16'h0000 || ifc.valid !== 1'b1) begin
            errors++; $display("FAIL reset_no_advance: got addr=%h valid=%b expected 0000 1", ifc.address, ifc.valid);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rom[i] = {OPC_STO, 24'($urandom)};
            else if (r < 8) rom[i] = {OPC_NOP, 24'($urandom_range(0, 4))};
            else            rom[i] = {OPC_JMP, 8'($urandom), 16'($urandom_range(0, 63))};
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ifc.run          = ($urandom_range(0, 7) != 0);
            ifc.ready        = ($urandom_range(0, 2) != 0);
            ifc.branch_taken = ($urandom_range(0, 40) == 0);
            ifc.branch_addr  = 16'($urandom_range(0, 63));
            rst              = ($urandom_range(0, 300) == 0);
            step();
            checks++;
            if (ifc.address !== m_pc || ifc.valid !== m_offered || ifc.instruction !== m_instr || ifc.busy !== (m_stall > 0)) begin
                errors++;
                $display("FAIL random_cycle%0d: got addr=%h valid=%b instr=%h busy=%b expected addr=%h valid=%b instr=%h busy=%b",
                         c, ifc.address, ifc.valid, ifc.instruction, ifc.busy, m_pc, m_offered, m_instr, (m_stall > 0));
            end
        end
        rst = 1'b0;
        ifc.branch_taken = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = {OPC_STO, 24'h000000};
        rst = 1'b1;
        ifc.run = 1'b0; ifc.ready = 1'b0;
        ifc.branch_taken = 1'b0; ifc.branch_addr = 16'h0000;
        test_reset();
        test_sequential();
        test_nop_delay();
        test_jmp_loop();
        test_stall_ready();
        test_branch_in_delay();
        test_wrap_and_reset_handshake();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
